// File: rtl/rbs_pkg.sv
// Shared types, constants and burst-sizing helper for the read burst sequencer.
package rbs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUN,
    DRAIN,
    FLUSH
  } rbs_state_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam int unsigned PAGE_BYTES     = 4096;

  // Beats for the next burst: bounded by what is left, the burst cap and the 4 KB page end.
  function automatic int unsigned burst_beats(input int unsigned remaining,
                                              input logic [11:0] page_off,
                                              input int unsigned beat_shift,
                                              input int unsigned max_burst);
    int unsigned page_beats;
    int unsigned beats;
    page_beats = (PAGE_BYTES - {20'd0, page_off}) >> beat_shift;
    beats      = remaining;
    if (max_burst < beats) beats = max_burst;
    if (page_beats < beats) beats = page_beats;
    return beats;
  endfunction

endpackage

// File: rtl/rbs_outstanding_ctr.sv
// Up/down counter of AR bursts issued but not yet closed by an rlast beat.
module rbs_outstanding_ctr #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [CNT_W-1:0] r_count;

  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign o_empty = (r_count == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && !o_full) begin
      r_count <= r_count + CNT_W'(1);
    end else if (i_dec && !i_inc && !o_empty) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/read_burst_sequencer.sv
// Splits one loaded read command into AXI4 INCR AR bursts capped in length and kept inside
// 4 KB pages, tracking completion on the R channel.
module read_burst_sequencer
  import rbs_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_DATA_WIDTH  = 64,
  parameter int unsigned TOP_LEN_WIDTH   = 20,
  parameter int unsigned MAX_BURST_LEN   = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_read_start,
  input  logic                      i_read_restart,
  input  logic                      i_top_read_valid,
  input  logic [TOP_LEN_WIDTH-1:0]  i_top_read_len,
  input  logic [AXI_ADDR_WIDTH-1:0] i_top_read_addr,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  output logic [AXI_ADDR_WIDTH-1:0] o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  input  logic                      i_rvalid,
  input  logic                      i_rready,
  input  logic                      i_rlast,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_cmd_drop
);

  localparam int unsigned BEAT_BYTES = AXI_DATA_WIDTH / 8;
  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int unsigned CNT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LOW_MASK = AXI_ADDR_WIDTH'(BEAT_BYTES - 1);

  rbs_state_t                r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [TOP_LEN_WIDTH-1:0]  r_remaining;
  logic [8:0]                r_beats;
  logic                      r_arvalid;
  logic [AXI_ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]                r_arlen;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_cmd_drop;

  int unsigned               w_beats;
  logic                      w_ar_hs;
  logic                      w_r_last;
  logic [CNT_W-1:0]          w_outstanding;
  logic                      w_full;
  logic                      w_empty;

  assign w_ar_hs  = r_arvalid && i_arready;
  assign w_r_last = i_rvalid && i_rready && i_rlast;
  assign w_beats  = burst_beats(32'(r_remaining), r_addr[11:0], BEAT_SHIFT, MAX_BURST_LEN);

  rbs_outstanding_ctr #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_ctr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (w_ar_hs),
    .i_dec  (w_r_last),
    .o_count(w_outstanding),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_beats     <= '0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_drop  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_cmd_drop <= 1'b0;
      // A pending AR is always carried to its handshake, even across a restart.
      if (w_ar_hs) r_arvalid <= 1'b0;

      if (i_read_restart) begin
        r_state     <= FLUSH;
        r_busy      <= 1'b1;
        r_addr      <= '0;
        r_remaining <= '0;
        r_cmd_drop  <= i_top_read_valid;
      end else begin
        case (r_state)
          IDLE, ARMED: begin
            if (i_top_read_valid) begin
              r_addr      <= i_top_read_addr & ~ADDR_LOW_MASK;
              r_remaining <= i_top_read_len;
              r_state     <= ARMED;
              r_busy      <= 1'b1;
            end
            if (r_state == ARMED && i_read_start) r_state <= RUN;
          end
          RUN: begin
            r_cmd_drop <= i_top_read_valid;
            if (r_arvalid) begin
              if (i_arready) begin
                r_addr      <= r_addr + (AXI_ADDR_WIDTH'(r_beats) << BEAT_SHIFT);
                r_remaining <= r_remaining - TOP_LEN_WIDTH'(r_beats);
              end
            end else if (r_remaining == '0) begin
              r_state <= DRAIN;
            end else if (!w_full) begin
              r_arvalid <= 1'b1;
              r_araddr  <= r_addr;
              r_arlen   <= 8'(w_beats - 1);
              r_beats   <= 9'(w_beats);
            end
          end
          DRAIN: begin
            r_cmd_drop <= i_top_read_valid;
            if (w_empty) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          FLUSH: begin
            r_cmd_drop <= i_top_read_valid;
            if (!r_arvalid && w_outstanding == '0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_arvalid  = r_arvalid;
  assign o_araddr   = r_araddr;
  assign o_arlen    = r_arlen;
  assign o_arsize   = 3'(BEAT_SHIFT);
  assign o_arburst  = AXI_BURST_INCR;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_cmd_drop = r_cmd_drop;

endmodule

// File: tb/tb_read_burst_sequencer.sv
// Directed bench for read_burst_sequencer: burst splitting, page limits, outstanding cap,
// restart flush, zero-length commands and asynchronous reset.
module tb_read_burst_sequencer;

  localparam int AW = 32;
  localparam int LW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_start, read_restart, top_read_valid;
  logic [LW-1:0] top_read_len;
  logic [AW-1:0] top_read_addr;
  logic          arready, rvalid, rready, rlast;
  logic          o_arvalid, o_busy, o_done, o_cmd_drop;
  logic [AW-1:0] o_araddr;
  logic [7:0]    o_arlen;
  logic [2:0]    o_arsize;
  logic [1:0]    o_arburst;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] ar_addr_q[$];
  logic [7:0]    ar_len_q[$];

  read_burst_sequencer u_dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_read_start    (read_start),
    .i_read_restart  (read_restart),
    .i_top_read_valid(top_read_valid),
    .i_top_read_len  (top_read_len),
    .i_top_read_addr (top_read_addr),
    .o_arvalid       (o_arvalid),
    .i_arready       (arready),
    .o_araddr        (o_araddr),
    .o_arlen         (o_arlen),
    .o_arsize        (o_arsize),
    .o_arburst       (o_arburst),
    .i_rvalid        (rvalid),
    .i_rready        (rready),
    .i_rlast         (rlast),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_cmd_drop      (o_cmd_drop)
  );

  always #5 clk = ~clk;

  // Log every AR handshake; inputs change only just after posedge, so negedge sees stable values.
  always @(negedge clk) begin
    if (!rst && o_arvalid && arready) begin
      ar_addr_q.push_back(o_araddr);
      ar_len_q.push_back(o_arlen);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    ar_addr_q.delete();
    ar_len_q.delete();
  endtask

  task automatic load(input logic [AW-1:0] addr, input logic [LW-1:0] len);
    top_read_valid = 1'b1;
    top_read_addr  = addr;
    top_read_len   = len;
    step();
    top_read_valid = 1'b0;
  endtask

  task automatic start();
    read_start = 1'b1;
    step();
    read_start = 1'b0;
  endtask

  task automatic wait_ar(input string tag, input int n);
    for (int i = 0; i < 80 && ar_addr_q.size() < n; i++) step();
    chk(tag, 64'(ar_addr_q.size()), 64'(n));
  endtask

  task automatic chk_ar(input string tag, input int idx, input logic [AW-1:0] addr,
                        input logic [7:0] len);
    if (idx < ar_addr_q.size()) begin
      chk({tag, "_addr"}, 64'(ar_addr_q[idx]), 64'(addr));
      chk({tag, "_len"}, 64'(ar_len_q[idx]), 64'(len));
    end else begin
      chk({tag, "_present"}, 64'(ar_addr_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic rlast_beats(input int n);
    rvalid = 1'b1;
    rready = 1'b1;
    rlast  = 1'b1;
    repeat (n) step();
    rvalid = 1'b0;
    rready = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic finish_cmd(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    rlast_beats(n);
    for (int i = 0; i < 10 && !seen; i++) begin
      if (o_done) seen = 1'b1;
      else step();
    end
    chk({tag, "_done"}, 64'(seen), 64'd1);
    chk({tag, "_idle"}, 64'(o_busy), 64'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    read_start = 1'b0; read_restart = 1'b0; top_read_valid = 1'b0;
    top_read_len = '0; top_read_addr = '0;
    arready = 1'b0; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    step();
    step();

    chk("rst_arvalid", 64'(o_arvalid), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_cmd_drop", 64'(o_cmd_drop), 64'd0);
    chk("rst_araddr", 64'(o_araddr), 64'd0);
    chk("rst_arlen", 64'(o_arlen), 64'd0);
    chk("rst_arsize", 64'(o_arsize), 64'd3);
    chk("rst_arburst", 64'(o_arburst), 64'd1);
    chk("rst_outstanding", 64'(u_dut.w_outstanding), 64'd0);
    rst = 1'b0;
    step();

    // 1: 40 beats at 0x1000 -> 16 + 16 + 8
    arready = 1'b1;
    load(32'h1000, 20'd40);
    chk("t1_armed_busy", 64'(o_busy), 64'd1);
    start();
    wait_ar("t1_ar_count", 3);
    chk_ar("t1_ar0", 0, 32'h1000, 8'd15);
    chk_ar("t1_ar1", 1, 32'h1080, 8'd15);
    chk_ar("t1_ar2", 2, 32'h1100, 8'd7);
    repeat (3) step();
    chk("t1_no_extra_ar", 64'(ar_addr_q.size()), 64'd3);
    chk("t1_outstanding", 64'(u_dut.w_outstanding), 64'd3);
    chk("t1_done_early", 64'(o_done), 64'd0);
    rlast_beats(3);
    chk("t1_done_same_cycle", 64'(o_done), 64'd0);
    step();
    chk("t1_done_pulse", 64'(o_done), 64'd1);
    chk("t1_busy_off", 64'(o_busy), 64'd0);
    step();
    chk("t1_done_one_cycle", 64'(o_done), 64'd0);

    // 2: page boundary split
    clear_q();
    load(32'h0FC0, 20'd16);
    start();
    wait_ar("t2_ar_count", 2);
    chk_ar("t2_ar0", 0, 32'h0FC0, 8'd7);
    chk_ar("t2_ar1", 1, 32'h1000, 8'd7);
    finish_cmd("t2", 2);

    // 3: R stalled -> cap at four outstanding bursts
    clear_q();
    load(32'h2000, 20'd80);
    start();
    wait_ar("t3_ar_count", 4);
    repeat (6) step();
    chk("t3_capped_count", 64'(ar_addr_q.size()), 64'd4);
    chk("t3_arvalid_low", 64'(o_arvalid), 64'd0);
    chk("t3_outstanding_max", 64'(u_dut.w_outstanding), 64'd4);
    rlast_beats(1);
    wait_ar("t3_ar_after_rlast", 5);
    chk_ar("t3_ar4", 4, 32'h2200, 8'd15);
    finish_cmd("t3", 4);

    // 4: restart with a stalled AR; restart also swallows a simultaneous command
    clear_q();
    arready = 1'b0;
    load(32'h3000, 20'd32);
    start();
    for (int i = 0; i < 20 && !o_arvalid; i++) step();
    chk("t4_arvalid_up", 64'(o_arvalid), 64'd1);
    read_restart   = 1'b1;
    top_read_valid = 1'b1;
    top_read_addr  = 32'h9000;
    top_read_len   = 20'd4;
    step();
    read_restart   = 1'b0;
    top_read_valid = 1'b0;
    chk("t4_cmd_drop", 64'(o_cmd_drop), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_arvalid", 64'(o_arvalid), 64'd1);
      chk("t4_hold_araddr", 64'(o_araddr), 64'h3000);
      chk("t4_hold_arlen", 64'(o_arlen), 64'd15);
      step();
    end
    chk("t4_flush_busy", 64'(o_busy), 64'd1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("t4_ar_taken", 64'(o_arvalid), 64'd0);
    chk("t4_outstanding", 64'(u_dut.w_outstanding), 64'd1);
    repeat (3) step();
    chk("t4_wait_rlast_busy", 64'(o_busy), 64'd1);
    chk("t4_single_ar", 64'(ar_addr_q.size()), 64'd1);
    rlast_beats(1);
    chk("t4_still_flush", 64'(o_busy), 64'd1);
    step();
    chk("t4_idle", 64'(o_busy), 64'd0);
    chk("t4_no_done", 64'(o_done), 64'd0);
    step();
    chk("t4_no_done_late", 64'(o_done), 64'd0);
    chk("t4_no_new_ar", 64'(ar_addr_q.size()), 64'd1);

    // 5: zero-length command, then a dropped command during RUN
    clear_q();
    arready = 1'b1;
    load(32'h4000, 20'd0);
    start();
    chk("t5_len0_run", 64'(o_done), 64'd0);
    step();
    chk("t5_len0_drain", 64'(o_done), 64'd0);
    step();
    chk("t5_len0_done", 64'(o_done), 64'd1);
    chk("t5_len0_no_ar", 64'(ar_addr_q.size()), 64'd0);
    step();
    load(32'h5000, 20'd8);
    start();
    load(32'h6000, 20'd100);
    chk("t5_cmd_drop", 64'(o_cmd_drop), 64'd1);
    step();
    chk("t5_cmd_drop_pulse", 64'(o_cmd_drop), 64'd0);
    wait_ar("t5_ar_count", 1);
    chk_ar("t5_ar0", 0, 32'h5000, 8'd7);
    repeat (3) step();
    chk("t5_cmd_unchanged", 64'(ar_addr_q.size()), 64'd1);
    finish_cmd("t5", 1);

    // 6: asynchronous reset mid-burst
    clear_q();
    load(32'h7000, 20'd48);
    start();
    wait_ar("t6_ar_count", 2);
    arready = 1'b0;
    for (int i = 0; i < 10 && !o_arvalid; i++) step();
    chk("t6_pending", 64'(o_arvalid), 64'd1);
    chk("t6_outstanding", 64'(u_dut.w_outstanding), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_arvalid", 64'(o_arvalid), 64'd0);
    chk("t6_rst_busy", 64'(o_busy), 64'd0);
    chk("t6_rst_outstanding", 64'(u_dut.w_outstanding), 64'd0);
    chk("t6_rst_araddr", 64'(o_araddr), 64'd0);
    step();
    rst = 1'b0;
    step();
    clear_q();
    arready = 1'b1;
    load(32'h8000, 20'd8);
    start();
    wait_ar("t6_new_ar_count", 1);
    chk_ar("t6_new_ar0", 0, 32'h8000, 8'd7);
    finish_cmd("t6", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
